// File: rtl/convert_integer_to_floatingpoint_seq.sv
// convert_integer_to_floatingpoint_seq
//
// Iterative integer to IEEE-754 single-precision converter. Each operand is
// normalised by shifting its magnitude left one bit per clock. The result is
// then rounded to nearest, ties to even, and presented as a registered float
// together with a one-cycle valid pulse.
//
// Build option:
//   INT2FP_SIGNED_EN  defined   -> Int is two's complement (negation logic built)
//                     undefined -> Int is unsigned, sign bit always 0
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   valid_in   operand valid
//   Int        WIDTH-bit integer operand, sampled only on accept
//   ready_out  high when an operand can be accepted (IDLE only)
//   valid_out  one-cycle pulse, FP is valid in that cycle
//   FP         {sign, exp[7:0], mant[22:0]}, held until the next result or reset
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an operand, ready_out high
// NORM  | shifting the magnitude left until its msb is set
// ROUND | round to nearest even, pack and register FP
// DONE  | valid_out high for this single cycle
module convert_integer_to_floatingpoint_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] Int,
    output logic             ready_out,
    output logic             valid_out,
    output logic [31:0]      FP
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Enough zero padding that the 23 mantissa bits, the guard bit and the
    // sticky field always exist, whatever WIDTH is. For WIDTH <= 24 the
    // guard and sticky bits come out as zero, so no rounding takes place.
    localparam int PAD = 56 - WIDTH;

    state_t           state;
    logic [WIDTH-1:0] mag;
    logic             sign;
    logic [7:0]       e;

    logic             sign_in;
    logic [WIDTH-1:0] abs_in;

`ifdef INT2FP_SIGNED_EN
    // The most negative value negates to itself. Read as unsigned, that is
    // exactly its magnitude.
    assign sign_in = Int[WIDTH-1];
    assign abs_in  = sign_in ? -Int : Int;
`else
    assign sign_in = 1'b0;
    assign abs_in  = Int;
`endif

    // The bits below the leading one, left-aligned in a 55-bit field.
    logic [54:0] frac_ext;
    logic [22:0] mant_trunc;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] mant_sum;
    logic [22:0] mant_final;
    logic [7:0]  exp_final;

    assign frac_ext   = {mag[WIDTH-2:0], {PAD{1'b0}}};
    assign mant_trunc = frac_ext[54:32];
    assign guard      = frac_ext[31];
    assign sticky     = |frac_ext[30:0];
    assign round_up   = guard & (sticky | mant_trunc[0]);
    assign mant_sum   = {1'b0, mant_trunc} + {23'd0, round_up};
    // A carry out of the mantissa leaves mant_sum[22:0] at zero already,
    // so only the exponent has to be bumped.
    assign mant_final = mant_sum[22:0];
    assign exp_final  = e + 8'd127 + {7'd0, mant_sum[23]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            FP        <= 32'd0;
            valid_out <= 1'b0;
            ready_out <= 1'b1;
            mag       <= '0;
            sign      <= 1'b0;
            e         <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    valid_out <= 1'b0;
                    if (valid_in && ready_out) begin
                        sign      <= sign_in;
                        mag       <= abs_in;
                        e         <= 8'(WIDTH - 1);
                        ready_out <= 1'b0;
                        if (abs_in == '0) begin
                            FP        <= 32'd0;
                            valid_out <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (mag[WIDTH-1]) begin
                        state <= ROUND;
                    end else begin
                        mag <= mag << 1;
                        e   <= e - 8'd1;
                    end
                end
                ROUND: begin
                    FP        <= {sign, exp_final, mant_final};
                    valid_out <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    valid_out <= 1'b0;
                    ready_out <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    valid_out <= 1'b0;
                    ready_out <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_convert_integer_to_floatingpoint_seq.sv
// Bench for convert_integer_to_floatingpoint_seq. Stimulus pushes the expected
// float and the expected valid_out cycle into queues. A monitor pops and
// compares whenever valid_out is seen. Build with INT2FP_SIGNED_EN to use the
// signed vector set.
module tb_convert_integer_to_floatingpoint_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_in;
    logic [W-1:0] int_s;
    logic         ready_out;
    logic         valid_out;
    logic [31:0]  FP;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    logic [31:0] exp_q[$];
    int          due_q[$];
    bit          ready_check_next = 1'b0;
    logic [31:0] mon_fp;
    int          mon_due;

    convert_integer_to_floatingpoint_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .Int       (int_s),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .FP        (FP)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    function automatic logic [W-1:0] mag_of(input logic [W-1:0] v);
`ifdef INT2FP_SIGNED_EN
        return v[W-1] ? -v : v;
`else
        return v;
`endif
    endfunction

    function automatic int lz(input logic [W-1:0] v);
        for (int i = W - 1; i >= 0; i--)
            if (v[i]) return W - 1 - i;
        return W;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (ready_check_next) begin
                total++;
                if (ready_out !== 1'b1) begin
                    bad++;
                    $display("FAIL ready_after_done: ready_out=%b want 1", ready_out);
                end
                ready_check_next = 1'b0;
            end
            if (valid_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: FP=%08h at cycle %0d, nothing pending", FP, cycle);
                end else begin
                    mon_fp  = exp_q.pop_front();
                    mon_due = due_q.pop_front();
                    total++;
                    if (FP !== mon_fp) begin
                        bad++;
                        $display("FAIL result: FP=%08h want %08h", FP, mon_fp);
                    end
                    total++;
                    if (cycle != mon_due) begin
                        bad++;
                        $display("FAIL latency: valid at cycle %0d want %0d", cycle, mon_due);
                    end
                    total++;
                    if (ready_out !== 1'b0) begin
                        bad++;
                        $display("FAIL ready_in_done: ready_out=%b want 0", ready_out);
                    end
                    ready_check_next = 1'b1;
                end
            end else if (exp_q.size() > 0) begin
                total++;
                if (ready_out !== 1'b0) begin
                    bad++;
                    $display("FAIL ready_busy: ready_out=%b want 0 at cycle %0d", ready_out, cycle);
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] v, input logic [31:0] expv);
        int budget = 0;
        int lat;
        @(negedge clk);
        while (ready_out !== 1'b1 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 200) begin
            total++;
            bad++;
            $display("FAIL send_timeout: ready_out=%b want 1", ready_out);
            return;
        end
        valid_in = 1'b1;
        int_s    = v;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        lat = (mag_of(v) == '0) ? 0 : lz(mag_of(v)) + 2;
        exp_q.push_back(expv);
        due_q.push_back(cycle + lat);
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d want 0", exp_q.size());
            exp_q.delete();
            due_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        valid_in = 1'b0;
        int_s    = '0;
        repeat (3) @(negedge clk);

        total++;
        if (FP !== 32'd0) begin bad++; $display("FAIL reset_fp: FP=%08h want 00000000", FP); end
        total++;
        if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: valid_out=%b want 0", valid_out); end
        total++;
        if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready: ready_out=%b want 1", ready_out); end
        rst = 1'b0;

`ifdef INT2FP_SIGNED_EN
        send(32'hFFFF_FFFF, 32'hBF80_0000);
        send(32'h8000_0000, 32'hCF00_0000);
        send(32'd100,       32'h42C8_0000);
        send(32'd0,         32'h0000_0000);
        send(32'h7FFF_FFFF, 32'h4F00_0000);
        send(32'hFFFF_FF9C, 32'hC2C8_0000);
        drain();
`else
        send(32'd1, 32'h3F80_0000);
        drain();
        send(32'd0,         32'h0000_0000);
        send(32'd16777217,  32'h4B80_0000);
        send(32'd16777219,  32'h4B80_0002);
        send(32'hFFFF_FFFF, 32'h4F80_0000);
        send(32'h7FFF_FFFF, 32'h4F00_0000);
        send(32'd255,       32'h437F_0000);
        send(32'd100,       32'h42C8_0000);
        drain();
`endif

        // An operand offered while busy must be dropped.
        send(32'd1, 32'h3F80_0000);
        repeat (3) @(negedge clk);
        valid_in = 1'b1;
        int_s    = 32'd5;
        repeat (4) @(negedge clk);
        valid_in = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        // Reset during NORM discards the conversion.
        @(negedge clk);
        valid_in = 1'b1;
        int_s    = 32'd1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (FP !== 32'd0) begin bad++; $display("FAIL midrst_fp: FP=%08h want 00000000", FP); end
        total++;
        if (ready_out !== 1'b1) begin bad++; $display("FAIL midrst_ready: ready_out=%b want 1", ready_out); end
        total++;
        if (valid_out !== 1'b0) begin bad++; $display("FAIL midrst_valid: valid_out=%b want 0", valid_out); end
        repeat (40) @(negedge clk);

        send(32'd3, 32'h4040_0000);
        drain();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: pending=%0d want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
